// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads (priority in active video, round-robin in blanking) vs a 1-entry write buffer.
// Read data 2 cycles after grant; writer backpressured via wr_ready_o while the buffer is full (1 word / 2 cycles max).
module vga_fb_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              blank_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [15:0]       wr_stall_cnt_o
);

  typedef enum logic { WB_EMPTY, WB_FULL } wb_state_t;
  typedef enum logic { GRANT_RD, GRANT_WR } grant_t;

  wb_state_t         wb_state;
  grant_t            last_grant;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              rd_inflight;
  logic              rd_pend;
  logic              wr_pend;
  logic              grant_rd;
  logic              grant_wr;

  // Reset masks both requesters so nothing reaches memory while it is held.
  always_comb begin
    rd_pend  = rd_req_i & ~reset_i;
    wr_pend  = (wb_state == WB_FULL) & ~reset_i;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (rd_pend && wr_pend) begin
      if (blank_i && last_grant == GRANT_RD) grant_wr = 1'b1;
      else                                   grant_rd = 1'b1;
    end else begin
      grant_rd = rd_pend;
      grant_wr = wr_pend;
    end
  end

  assign mem_en_o    = grant_rd | grant_wr;
  assign mem_we_o    = grant_wr;
  assign mem_addr_o  = grant_wr ? wb_addr : rd_addr_i;
  assign mem_wdata_o = wb_data;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wb_state       <= WB_EMPTY;
      wr_ready_o     <= 1'b1;
      last_grant     <= GRANT_WR;
      rd_inflight    <= 1'b0;
      rd_valid_o     <= 1'b0;
      rd_data_o      <= '0;
      wr_stall_cnt_o <= '0;
    end else begin
      unique case (wb_state)
        WB_EMPTY: if (wr_valid_i) begin
          wb_state   <= WB_FULL;
          wr_ready_o <= 1'b0;
          wb_addr    <= wr_addr_i;
          wb_data    <= wr_data_i;
        end
        WB_FULL: if (grant_wr) begin
          wb_state   <= WB_EMPTY;
          wr_ready_o <= 1'b1;
        end
        default: wb_state <= WB_EMPTY;
      endcase

      if (grant_rd)      last_grant <= GRANT_RD;
      else if (grant_wr) last_grant <= GRANT_WR;

      // Memory returns data the cycle after the access; register it once more.
      rd_inflight <= grant_rd;
      rd_valid_o  <= rd_inflight;
      if (rd_inflight) rd_data_o <= mem_rdata_i;

      if (wr_valid_i && !wr_ready_o && wr_stall_cnt_o != 16'hFFFF)
        wr_stall_cnt_o <= wr_stall_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: queue-based reference model checked every cycle plus literal spot checks.
module tb_vga_fb_arbiter;
  localparam int AW = 17;
  localparam int DW = 12;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1, blank_i = 1'b0, rd_req_i = 1'b0, wr_valid_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0, wr_addr_i = '0;
  logic [DW-1:0] wr_data_i = '0, mem_rdata_i = '0;
  logic          rd_valid_o, wr_ready_o, mem_en_o, mem_we_o;
  logic [DW-1:0] rd_data_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [15:0]   wr_stall_cnt_o;

  always #5 clk_i = ~clk_i;

  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .blank_i(blank_i),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .wr_stall_cnt_o(wr_stall_cnt_o)
  );

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int due; logic [DW-1:0] d; } rd_t;

  int            n_tests = 0, n_fail = 0, cyc = 0, exp_stall = 0;
  bit            chk_en = 1'b0, lg_read = 1'b0, g_rd, g_wr;
  logic [DW-1:0] mem [0:255];
  wr_t           wq[$];
  rd_t           rq[$];
  logic          s_en, s_we, s_rv, s_rdy;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wd, s_rd;
  logic [15:0]   s_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: derive the expected grant from the rules, compare at the negedge, advance the model.
  task automatic tick();
    bit  rp, wp, rv_exp, acc;
    rd_t r;
    wr_t w;
    rp = rd_req_i && !reset_i;
    wp = (wq.size() != 0) && !reset_i;
    // Reads win unless blanking and reads won the last contest.
    g_rd = rp && (!wp || !blank_i || !lg_read);
    g_wr = wp && !g_rd;
    @(negedge clk_i);
    s_en = mem_en_o; s_we = mem_we_o; s_addr = mem_addr_o; s_wd = mem_wdata_o;
    s_rv = rd_valid_o; s_rd = rd_data_o; s_rdy = wr_ready_o; s_stall = wr_stall_cnt_o;
    rv_exp = (rq.size() != 0) && (rq[0].due == cyc);
    if (chk_en) begin
      chk("mem_en", 32'(mem_en_o), 32'(g_rd | g_wr));
      chk("mem_we", 32'(mem_we_o), 32'(g_wr));
      if (g_rd) chk("rd_addr", 32'(mem_addr_o), 32'(rd_addr_i));
      if (g_wr) begin
        chk("wr_addr", 32'(mem_addr_o), 32'(wq[0].a));
        chk("wr_data", 32'(mem_wdata_o), 32'(wq[0].d));
      end
      chk("wr_ready", 32'(wr_ready_o), 32'(wq.size() == 0));
      chk("rd_valid", 32'(rd_valid_o), 32'(rv_exp));
      if (rv_exp) chk("rd_data", 32'(rd_data_o), 32'(rq[0].d));
      chk("stall_cnt", 32'(wr_stall_cnt_o), 32'(exp_stall));
    end
    if (rv_exp) void'(rq.pop_front());
    @(posedge clk_i);
    #1;
    mem_rdata_i = DW'($urandom);
    if (reset_i) begin
      wq.delete(); rq.delete(); lg_read = 1'b0; exp_stall = 0;
    end else begin
      if (wr_valid_i && wq.size() != 0 && exp_stall < 65535) exp_stall++;
      acc = wr_valid_i && (wq.size() == 0);
      if (g_wr) begin
        mem[wq[0].a[7:0]] = wq[0].d;
        void'(wq.pop_front());
        lg_read = 1'b0;
      end
      if (g_rd) begin
        r.due = cyc + 2; r.d = mem[rd_addr_i[7:0]];
        rq.push_back(r);
        mem_rdata_i = r.d;
        lg_read = 1'b1;
      end
      if (acc) begin
        w.a = wr_addr_i; w.d = wr_data_i;
        wq.push_back(w);
      end
    end
    cyc++;
  endtask

  task automatic set_in(input logic rst, input logic blk, input logic rr, input logic [AW-1:0] ra,
                        input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    reset_i = rst; blank_i = blk; rd_req_i = rr; rd_addr_i = ra;
    wr_valid_i = wv; wr_addr_i = wa; wr_data_i = wd;
  endtask

  initial begin
    int   nw, ne;
    logic [7:0]  gseq;
    logic [15:0] rseq;
    logic [2:0]  vec [0:15];
    for (int i = 0; i < 256; i++) mem[i] = DW'(i * 37 + 5);
    mem[8'h10] = 12'hABC;

    // Reset, with both requesters active while it is held.
    tick();
    chk_en = 1'b1;
    set_in(1, 0, 1, 17'h00033, 1, 17'h00044, 12'h111);
    tick();
    chk("rst_mem_en", 32'(s_en), 32'd0);
    chk("rst_rd_data", 32'(s_rd), 32'd0);
    chk("rst_stall", 32'(s_stall), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rst_ready", 32'(s_rdy), 32'd1);
    chk("rst_rd_valid", 32'(s_rv), 32'd0);

    // Single read at 0x00010 returns 0xABC two cycles later.
    set_in(0, 0, 1, 17'h00010, 0, 0, 0);
    tick();
    chk("rd1_grant", {30'd0, s_en, s_we}, 32'd2);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rd1_valid", 32'(s_rv), 32'd1);
    chk("rd1_data", 32'(s_rd), 32'hABC);

    // Active video with reads every cycle starves the buffered write.
    nw = 0;
    for (int i = 0; i < 100; i++) begin
      set_in(0, 0, 1, AW'(8'h20 + i), 1, 17'h00020, 12'h5A5);
      tick();
      if (s_en && s_we) nw++;
    end
    chk("starve_writes", 32'(nw), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("starve_stall", 32'(s_stall), 32'd99);
    chk("starve_release", {s_en, s_we, 14'd0, 4'd0, s_wd}, {1'b1, 1'b1, 14'd0, 4'd0, 12'h5A5});
    chk("starve_addr", 32'(s_addr), 32'h20);

    // Blanking contention alternates, first contested grant to read after reset.
    set_in(1, 1, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 1, 0, 0, 1, 17'h00050, 12'h050);
    tick();
    gseq = '0; ne = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, 1, AW'(8'h60 + i), 1, AW'(8'h50 + i), DW'(12'h050 + i));
      tick();
      gseq[i] = s_we;
      if (s_en) ne++;
    end
    chk("rr_sequence", 32'(gseq), 32'hAA);
    chk("rr_grants", 32'(ne), 32'd8);

    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // Write streaming with no reads: one word every two cycles.
    nw = 0; rseq = '0;
    for (int t = 0; t < 16; t++) begin
      set_in(0, 0, 0, 0, 1, AW'(17'h00100 + t / 2), DW'(12'h300 + t / 2));
      tick();
      rseq[t] = s_rdy;
      if (s_en && s_we) begin
        chk("stream_order", 32'(s_addr), 32'(17'h00100 + nw));
        nw++;
      end
    end
    chk("stream_ready", 32'(rseq), 32'h5555);
    chk("stream_count", 32'(nw), 32'd8);

    // Mixed directed vectors {blank, rd_req, wr_valid}, including blank toggling.
    vec = '{3'b111, 3'b011, 3'b111, 3'b101, 3'b011, 3'b110, 3'b111, 3'b001,
            3'b111, 3'b111, 3'b010, 3'b101, 3'b111, 3'b011, 3'b100, 3'b000};
    for (int i = 0; i < 16; i++) begin
      set_in(0, vec[i][2], vec[i][1], AW'(8'h70 + i), vec[i][0], AW'(8'h80 + i), DW'(12'h900 + i));
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // Reset with a buffered write and a read in flight.
    set_in(0, 0, 1, 17'h00010, 1, 17'h000A0, 12'hDEF);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rstmid_no_access", 32'(s_en), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    ne = 0; nw = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) chk("rstmid_ready", 32'(s_rdy), 32'd1);
      if (s_en) ne++;
      if (s_rv) nw++;
    end
    chk("rstmid_no_write", 32'(ne), 32'd0);
    chk("rstmid_no_rvalid", 32'(nw), 32'd0);

    // Long stall saturates the counter.
    for (int i = 0; i < 70000; i++) begin
      set_in(0, 0, 1, AW'(i % 256), 1, 17'h000B0, 12'h0B0);
      tick();
    end
    set_in(0, 0, 1, 0, 1, 17'h000B0, 12'h0B0);
    tick();
    chk("stall_saturate", 32'(s_stall), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
- REQ-001: Parameter ADDR_W, default 17, framebuffer word-address width.
- REQ-002: Parameter DATA_W, default 12, pixel word width (4:4:4 RGB).
- REQ-003: clk_i  in  1  pixel clock; single clock domain; all logic rising-edge.
- REQ-004: reset_i  in  1  synchronous, active-high reset.
- REQ-005: blank_i  in  1  1 = display blanking interval, 0 = active video.
- REQ-006: rd_req_i  in  1  scanout read request, one word per asserted cycle.
- REQ-007: rd_addr_i  in  ADDR_W  scanout read address.
- REQ-008: rd_valid_o  out  1  read-data strobe.
- REQ-009: rd_data_o  out  DATA_W  read data.
- REQ-010: wr_valid_i  in  1  writer offers a word.
- REQ-011: wr_ready_o  out  1  write buffer can accept a word.
- REQ-012: wr_addr_i  in  ADDR_W  write address.
- REQ-013: wr_data_i  in  DATA_W  write data.
- REQ-014: mem_en_o  out  1  memory access this cycle.
- REQ-015: mem_we_o  out  1  1 = write, 0 = read; meaningful only with mem_en_o.
- REQ-016: mem_addr_o  out  ADDR_W  memory address.
- REQ-017: mem_wdata_o  out  DATA_W  memory write data.
- REQ-018: mem_rdata_i  in  DATA_W  memory read data, valid exactly 1 cycle after a read access.
- REQ-019: wr_stall_cnt_o  out  16  saturating count of cycles with wr_valid_i=1 and wr_ready_o=0.

Function
- REQ-020: One memory access per cycle, single port; block SHALL never issue a read and a write in the same cycle.
- REQ-021: Write buffer: single entry, states EMPTY/FULL; wr_ready_o = 1 iff EMPTY, registered.
- REQ-022: EMPTY -> FULL when wr_valid_i & wr_ready_o; captures wr_addr_i/wr_data_i.
- REQ-023: FULL -> EMPTY on the cycle the buffered write is granted to memory; no load in the same cycle (max write throughput 1 word / 2 cycles).
- REQ-024: Memory outputs combinational from the current-cycle grant.
- REQ-025: Active video (blank_i=0): read has absolute priority; rd_req_i=1 -> read granted; buffered write granted only in cycles with rd_req_i=0.
- REQ-026: Blanking (blank_i=1), both pending: round-robin via last_grant flag; grant the type not granted last; last_grant updates on every grant (read or write), in any phase.
- REQ-027: Only one type pending -> that type is granted, regardless of phase.
- REQ-028: Read latency: read granted in cycle N -> rd_valid_o=1 in cycle N+2, with rd_data_o = mem_rdata_i sampled at N+1 (registered); back-to-back reads stream one word per cycle.
- REQ-029: Read request not granted (blanking round-robin loss) is dropped, not queued; requester re-asserts.
- REQ-030: mem_en_o=0 and mem_we_o=0 when nothing granted; mem_addr_o/mem_wdata_o don't-care then.
- REQ-031: Write granted: mem_en_o=1, mem_we_o=1, mem_addr_o/mem_wdata_o from buffer.
- REQ-032: wr_stall_cnt_o increments per stall cycle; saturates at 16'hFFFF.
- REQ-033: blank_i change takes effect in the same cycle's arbitration.

Reset
- REQ-034: reset_i=1 at a clock edge: buffer EMPTY, wr_ready_o=1, last_grant=write (first contended blanking grant goes to read), rd_valid_o=0, rd_data_o=0, wr_stall_cnt_o=0, in-flight read pipeline discarded.
- REQ-035: While reset_i=1: mem_en_o=0, mem_we_o=0; no handshakes accepted.
- REQ-036: Reset mid-write: buffered word discarded, never written.

Verification
- REQ-037: Reset, then single read addr 0x00010, mem_rdata_i=0xABC at N+1 -> rd_valid_o=1, rd_data_o=0xABC at N+2.
- REQ-038: blank_i=0, rd_req_i=1 for 100 cycles, write buffered -> no write issued; wr_stall_cnt_o rises while wr_valid_i held; write issues first cycle rd_req_i=0.
- REQ-039: blank_i=1, both pending continuously -> grants alternate R,W,R,W starting with read after reset.
- REQ-040: Writer streams 8 words with no reads -> wr_ready_o toggles 1,0,1,0; 8 writes issued in 16 cycles, correct addr/data order.
- REQ-041: Hold stall 70000 cycles -> wr_stall_cnt_o = 0xFFFF, no wrap.
- REQ-042: reset_i pulse with buffer FULL and read in flight -> no memory write, no rd_valid_o pulse, wr_ready_o=1 next cycle.
